// File: rtl/ahb_lite_master_arb.sv
// Two-master AHB-lite arbiter: one-entry address buffer per master, registered
// bus address phase, data-phase signals steered by a one-hot owner.
module ahb_lite_master_arb #(
    parameter int unsigned RR = 0,
    parameter int unsigned AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] HADDR_M0,
    input  logic [1:0]    HTRANS_M0,
    input  logic          HWRITE_M0,
    input  logic [2:0]    HSIZE_M0,
    input  logic [31:0]   HWDATA_M0,
    output logic          HREADY_M0,
    output logic [31:0]   HRDATA_M0,
    input  logic [AW-1:0] HADDR_M1,
    input  logic [1:0]    HTRANS_M1,
    input  logic          HWRITE_M1,
    input  logic [2:0]    HSIZE_M1,
    input  logic [31:0]   HWDATA_M1,
    output logic          HREADY_M1,
    output logic [31:0]   HRDATA_M1,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic [31:0]   HRDATA,
    output logic [1:0]    DP_OWNER
);
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ADDR, ST_DATA} state_e;

    state_e        m0_state_q, m0_state_d;
    state_e        m1_state_q, m1_state_d;
    logic [AW-1:0] m0_addr_q, m0_addr_d, m1_addr_q, m1_addr_d;
    logic          m0_write_q, m0_write_d, m1_write_q, m1_write_d;
    logic [2:0]    m0_size_q, m0_size_d, m1_size_q, m1_size_d;
    logic [AW-1:0] haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic          last_grant_q, last_grant_d;

    logic req_m0, req_m1, pend_m0, pend_m1;
    logic grant_m1, load, cap_m0, cap_m1;
    logic unused_trans;

    // SEQ is reissued as NONSEQ, so only the request bit of HTRANS matters.
    assign unused_trans = HTRANS_M0[0] ^ HTRANS_M1[0];

    function automatic state_e next_state(input state_e cur, input logic req,
                                          input logic granted, input logic rdy);
        state_e nxt;
        nxt = cur;
        case (cur)
            ST_IDLE: if (req) nxt = ST_PEND;
            ST_PEND: if (granted) nxt = ST_ADDR;
            ST_ADDR: if (rdy) nxt = ST_DATA;
            ST_DATA: if (rdy) nxt = req ? ST_PEND : ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    always_comb begin
        req_m0  = HTRANS_M0[1];
        req_m1  = HTRANS_M1[1];
        pend_m0 = (m0_state_q == ST_PEND);
        pend_m1 = (m1_state_q == ST_PEND);
        load    = HREADY && (pend_m0 || pend_m1);

        // A lone candidate always wins; the mode only breaks ties.
        if (pend_m0 && pend_m1) grant_m1 = (RR != 0) ? ~last_grant_q : 1'b0;
        else                    grant_m1 = pend_m1;

        cap_m0 = req_m0 && ((m0_state_q == ST_IDLE) || ((m0_state_q == ST_DATA) && HREADY));
        cap_m1 = req_m1 && ((m1_state_q == ST_IDLE) || ((m1_state_q == ST_DATA) && HREADY));

        m0_state_d = next_state(m0_state_q, req_m0, load && !grant_m1, HREADY);
        m1_state_d = next_state(m1_state_q, req_m1, load && grant_m1, HREADY);

        m0_addr_d  = cap_m0 ? HADDR_M0  : m0_addr_q;
        m0_write_d = cap_m0 ? HWRITE_M0 : m0_write_q;
        m0_size_d  = cap_m0 ? HSIZE_M0  : m0_size_q;
        m1_addr_d  = cap_m1 ? HADDR_M1  : m1_addr_q;
        m1_write_d = cap_m1 ? HWRITE_M1 : m1_write_q;
        m1_size_d  = cap_m1 ? HSIZE_M1  : m1_size_q;

        haddr_d      = haddr_q;
        htrans_d     = htrans_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        last_grant_d = last_grant_q;
        if (load) begin
            haddr_d      = grant_m1 ? m1_addr_q  : m0_addr_q;
            hwrite_d     = grant_m1 ? m1_write_q : m0_write_q;
            hsize_d      = grant_m1 ? m1_size_q  : m0_size_q;
            htrans_d     = 2'b10;
            last_grant_d = grant_m1;
        end else if (HREADY) begin
            htrans_d = 2'b00;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            m0_state_q   <= ST_IDLE;
            m1_state_q   <= ST_IDLE;
            m0_addr_q    <= '0;
            m0_write_q   <= 1'b0;
            m0_size_q    <= '0;
            m1_addr_q    <= '0;
            m1_write_q   <= 1'b0;
            m1_size_q    <= '0;
            haddr_q      <= '0;
            htrans_q     <= 2'b00;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            m0_state_q   <= m0_state_d;
            m1_state_q   <= m1_state_d;
            m0_addr_q    <= m0_addr_d;
            m0_write_q   <= m0_write_d;
            m0_size_q    <= m0_size_d;
            m1_addr_q    <= m1_addr_d;
            m1_write_q   <= m1_write_d;
            m1_size_q    <= m1_size_d;
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        DP_OWNER  = {m1_state_q == ST_DATA, m0_state_q == ST_DATA};
        HREADY_M0 = (m0_state_q == ST_IDLE) || ((m0_state_q == ST_DATA) && HREADY);
        HREADY_M1 = (m1_state_q == ST_IDLE) || ((m1_state_q == ST_DATA) && HREADY);
        HRDATA_M0 = HRDATA;
        HRDATA_M1 = HRDATA;
        if (DP_OWNER[0])      HWDATA = HWDATA_M0;
        else if (DP_OWNER[1]) HWDATA = HWDATA_M1;
        else                  HWDATA = '0;
        HADDR  = haddr_q;
        HTRANS = htrans_q;
        HWRITE = hwrite_q;
        HSIZE  = hsize_q;
    end
endmodule

// File: tb/tb_ahb_lite_master_arb.sv
// Bench for ahb_lite_master_arb: fixed-priority and round-robin instances share
// stimulus; directed steps plus random traffic against a transaction-level model.
module tb_ahb_lite_master_arb;
    localparam int S_IDLE = 0;
    localparam int S_WAIT = 1;
    localparam int S_BUS  = 2;
    localparam int S_DATA = 3;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESET, HREADY;
    logic [31:0] HRDATA;
    logic [31:0] addr_m  [2];
    logic [1:0]  trans_m [2];
    logic        write_m [2];
    logic [2:0]  size_m  [2];
    logic [31:0] wdata_m [2];

    logic [31:0] o_haddr [2];
    logic [1:0]  o_htrans[2];
    logic        o_hwrite[2];
    logic [2:0]  o_hsize [2];
    logic [31:0] o_hwdata[2];
    logic [1:0]  o_dp    [2];
    logic        o_rdy0  [2];
    logic        o_rdy1  [2];
    logic [31:0] o_rd0   [2];
    logic [31:0] o_rd1   [2];

    ahb_lite_master_arb #(.RR(0), .AW(32)) u_fp (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M0(addr_m[0]), .HTRANS_M0(trans_m[0]), .HWRITE_M0(write_m[0]),
        .HSIZE_M0(size_m[0]), .HWDATA_M0(wdata_m[0]),
        .HREADY_M0(o_rdy0[0]), .HRDATA_M0(o_rd0[0]),
        .HADDR_M1(addr_m[1]), .HTRANS_M1(trans_m[1]), .HWRITE_M1(write_m[1]),
        .HSIZE_M1(size_m[1]), .HWDATA_M1(wdata_m[1]),
        .HREADY_M1(o_rdy1[0]), .HRDATA_M1(o_rd1[0]),
        .HADDR(o_haddr[0]), .HTRANS(o_htrans[0]), .HWRITE(o_hwrite[0]), .HSIZE(o_hsize[0]),
        .HWDATA(o_hwdata[0]), .HREADY(HREADY), .HRDATA(HRDATA), .DP_OWNER(o_dp[0])
    );

    ahb_lite_master_arb #(.RR(1), .AW(32)) u_rr (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M0(addr_m[0]), .HTRANS_M0(trans_m[0]), .HWRITE_M0(write_m[0]),
        .HSIZE_M0(size_m[0]), .HWDATA_M0(wdata_m[0]),
        .HREADY_M0(o_rdy0[1]), .HRDATA_M0(o_rd0[1]),
        .HADDR_M1(addr_m[1]), .HTRANS_M1(trans_m[1]), .HWRITE_M1(write_m[1]),
        .HSIZE_M1(size_m[1]), .HWDATA_M1(wdata_m[1]),
        .HREADY_M1(o_rdy1[1]), .HRDATA_M1(o_rd1[1]),
        .HADDR(o_haddr[1]), .HTRANS(o_htrans[1]), .HWRITE(o_hwrite[1]), .HSIZE(o_hsize[1]),
        .HWDATA(o_hwdata[1]), .HREADY(HREADY), .HRDATA(HRDATA), .DP_OWNER(o_dp[1])
    );

    // Reference model: index [d] is the instance (0 fixed, 1 round-robin), [m] the master.
    int          stg     [2][2];
    logic [31:0] bq_addr [2][2];
    logic        bq_write[2][2];
    logic [2:0]  bq_size [2][2];
    logic [31:0] bus_addr [2];
    logic [1:0]  bus_trans[2];
    logic        bus_write[2];
    logic [2:0]  bus_size [2];
    int          last     [2];

    int checks = 0;
    int errors = 0;
    int ord0[$];
    int ord1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        for (int m = 0; m < 2; m++) begin
            stg[d][m] = S_IDLE;
            bq_addr[d][m] = '0;
            bq_write[d][m] = 1'b0;
            bq_size[d][m] = '0;
        end
        bus_addr[d] = '0;
        bus_trans[d] = 2'b00;
        bus_write[d] = 1'b0;
        bus_size[d] = '0;
        last[d] = 1;
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int win;
            win = -1;
            if (HRESET) begin
                model_reset(d);
            end else begin
                if (HREADY) begin
                    if (stg[d][0] == S_WAIT && stg[d][1] == S_WAIT) win = (d == 1) ? 1 - last[d] : 0;
                    else if (stg[d][0] == S_WAIT) win = 0;
                    else if (stg[d][1] == S_WAIT) win = 1;
                    if (win >= 0) begin
                        bus_addr[d]  = bq_addr[d][win];
                        bus_write[d] = bq_write[d][win];
                        bus_size[d]  = bq_size[d][win];
                        bus_trans[d] = 2'b10;
                        last[d] = win;
                    end else begin
                        bus_trans[d] = 2'b00;
                    end
                end
                for (int m = 0; m < 2; m++) begin
                    logic take;
                    take = 1'b0;
                    case (stg[d][m])
                        S_IDLE: take = trans_m[m][1];
                        S_WAIT: if (win == m) stg[d][m] = S_BUS;
                        S_BUS:  if (HREADY) stg[d][m] = S_DATA;
                        default: if (HREADY) begin
                            take = trans_m[m][1];
                            if (!take) stg[d][m] = S_IDLE;
                        end
                    endcase
                    if (take) begin
                        stg[d][m] = S_WAIT;
                        bq_addr[d][m]  = addr_m[m];
                        bq_write[d][m] = write_m[m];
                        bq_size[d][m]  = size_m[m];
                    end
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge HCLK);
        for (int d = 0; d < 2; d++) begin
            logic        r0, r1;
            logic [1:0]  dp;
            logic [31:0] wd;
            r0 = (stg[d][0] == S_IDLE) || (stg[d][0] == S_DATA && HREADY);
            r1 = (stg[d][1] == S_IDLE) || (stg[d][1] == S_DATA && HREADY);
            dp = {stg[d][1] == S_DATA, stg[d][0] == S_DATA};
            wd = dp[0] ? wdata_m[0] : (dp[1] ? wdata_m[1] : 32'h0);
            chk($sformatf("d%0d_htrans", d), 32'(o_htrans[d]), 32'(bus_trans[d]));
            chk($sformatf("d%0d_haddr", d), o_haddr[d], bus_addr[d]);
            chk($sformatf("d%0d_hwrite", d), 32'(o_hwrite[d]), 32'(bus_write[d]));
            chk($sformatf("d%0d_hsize", d), 32'(o_hsize[d]), 32'(bus_size[d]));
            chk($sformatf("d%0d_hwdata", d), o_hwdata[d], wd);
            chk($sformatf("d%0d_dp_owner", d), 32'(o_dp[d]), 32'(dp));
            chk($sformatf("d%0d_hready_m0", d), 32'(o_rdy0[d]), 32'(r0));
            chk($sformatf("d%0d_hready_m1", d), 32'(o_rdy1[d]), 32'(r1));
            chk($sformatf("d%0d_hrdata_m0", d), o_rd0[d], HRDATA);
            chk($sformatf("d%0d_hrdata_m1", d), o_rd1[d], HRDATA);
        end
    endtask

    task automatic clk_edge();
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    task automatic cyc();
        settle();
        clk_edge();
    endtask

    initial begin
        HRESET = 1'b1;
        HREADY = 1'b1;
        HRDATA = '0;
        for (int m = 0; m < 2; m++) begin
            addr_m[m] = '0; trans_m[m] = 2'b00; write_m[m] = 1'b0;
            size_m[m] = '0; wdata_m[m] = '0;
        end
        // Reset with a request present: it must not be captured.
        trans_m[0] = 2'b10;
        addr_m[0]  = 32'h0000_1234;
        clk_edge();
        clk_edge();
        HRESET = 1'b0;
        trans_m[0] = 2'b00;
        settle();
        for (int d = 0; d < 2; d++) begin
            chk("rst_htrans", 32'(o_htrans[d]), 32'h0);
            chk("rst_rdy0", 32'(o_rdy0[d]), 32'h1);
            chk("rst_rdy1", 32'(o_rdy1[d]), 32'h1);
            chk("rst_dp", 32'(o_dp[d]), 32'h0);
            chk("rst_hwdata", o_hwdata[d], 32'h0);
        end
        clk_edge();
        repeat (2) begin
            settle();
            for (int d = 0; d < 2; d++) chk("rst_no_xfer", 32'(o_htrans[d]), 32'h0);
            clk_edge();
        end

        // Single M0 read, zero-wait slave.
        HRDATA = 32'hDEAD_BEEF;
        trans_m[0] = 2'b10; addr_m[0] = 32'h2000_0010; write_m[0] = 1'b0; size_m[0] = 3'd2;
        settle();
        chk("rd_accept_rdy0", 32'(o_rdy0[0]), 32'h1);
        clk_edge();
        trans_m[0] = 2'b00;
        settle();
        chk("rd_rdy0_c1", 32'(o_rdy0[0]), 32'h0);
        clk_edge();
        settle();
        for (int d = 0; d < 2; d++) begin
            chk("rd_haddr", o_haddr[d], 32'h2000_0010);
            chk("rd_htrans", 32'(o_htrans[d]), 32'h2);
            chk("rd_rdy0_c2", 32'(o_rdy0[d]), 32'h0);
        end
        clk_edge();
        settle();
        for (int d = 0; d < 2; d++) begin
            chk("rd_rdy0_done", 32'(o_rdy0[d]), 32'h1);
            chk("rd_hrdata0", o_rd0[d], 32'hDEAD_BEEF);
            chk("rd_dp", 32'(o_dp[d]), 32'h1);
        end
        clk_edge();
        settle();
        chk("rd_dp_after", 32'(o_dp[0]), 32'h0);
        clk_edge();

        // Same-edge requests: M0 write 0x1, M1 read 0x2.
        trans_m[0] = 2'b10; addr_m[0] = 32'h1; write_m[0] = 1'b1; wdata_m[0] = 32'hA5A5_A5A5;
        trans_m[1] = 2'b10; addr_m[1] = 32'h2; write_m[1] = 1'b0;
        cyc();
        trans_m[0] = 2'b00; trans_m[1] = 2'b00;
        settle();
        clk_edge();
        settle();
        chk("fp_first_addr", o_haddr[0], 32'h1);
        chk("fp_first_write", 32'(o_hwrite[0]), 32'h1);
        chk("rr_first_addr", o_haddr[1], 32'h2);
        clk_edge();
        settle();
        chk("fp_second_addr", o_haddr[0], 32'h2);
        chk("fp_second_htrans", 32'(o_htrans[0]), 32'h2);
        chk("fp_m0_dp", 32'(o_dp[0]), 32'h1);
        chk("fp_m0_hwdata", o_hwdata[0], 32'hA5A5_A5A5);
        chk("fp_m1_wait", 32'(o_rdy1[0]), 32'h0);
        clk_edge();
        settle();
        chk("fp_m1_dp", 32'(o_dp[0]), 32'h2);
        chk("fp_m1_done", 32'(o_rdy1[0]), 32'h1);
        clk_edge();
        repeat (3) cyc();

        // Continuous requests from both masters.
        HRESET = 1'b1;
        cyc();
        HRESET = 1'b0;
        for (int i = 0; i < 24; i++) begin
            trans_m[0] = (i < 20) ? 2'b10 : 2'b00;
            trans_m[1] = (i < 20) ? 2'b10 : 2'b00;
            addr_m[0] = 32'h1000_0000 + 32'(i);
            addr_m[1] = 32'h2000_0000 + 32'(i);
            settle();
            if (o_htrans[0] == 2'b10) ord0.push_back(int'(o_haddr[0][29]));
            if (o_htrans[1] == 2'b10) ord1.push_back(int'(o_haddr[1][29]));
            clk_edge();
        end
        chk("fp_issue_count", 32'(ord0.size() >= 12), 32'h1);
        chk("rr_issue_count", 32'(ord1.size() >= 12), 32'h1);
        for (int k = 0; k < 12; k++) begin
            if (k < ord1.size()) chk($sformatf("rr_order%0d", k), 32'(ord1[k]), 32'(k % 2));
            if (k < ord0.size()) chk($sformatf("fp_order%0d", k), 32'(ord0[k]), 32'(k % 2));
        end
        repeat (4) cyc();

        // Wait states during M1 data phase with M0 in address phase.
        wdata_m[0] = 32'h3333_4444; wdata_m[1] = 32'h1111_2222;
        trans_m[1] = 2'b10; addr_m[1] = 32'h3000_0004; write_m[1] = 1'b0;
        cyc();
        trans_m[1] = 2'b00;
        trans_m[0] = 2'b10; addr_m[0] = 32'h4000_0008; write_m[0] = 1'b1;
        cyc();
        trans_m[0] = 2'b00;
        cyc();
        HREADY = 1'b0;
        repeat (3) begin
            settle();
            for (int d = 0; d < 2; d++) begin
                chk("ws_haddr", o_haddr[d], 32'h4000_0008);
                chk("ws_htrans", 32'(o_htrans[d]), 32'h2);
                chk("ws_rdy0", 32'(o_rdy0[d]), 32'h0);
                chk("ws_rdy1", 32'(o_rdy1[d]), 32'h0);
                chk("ws_dp", 32'(o_dp[d]), 32'h2);
            end
            clk_edge();
        end
        HREADY = 1'b1;
        HRDATA = 32'hCAFE_F00D;
        settle();
        chk("ws_m1_done", 32'(o_rdy1[0]), 32'h1);
        chk("ws_m1_hrdata", o_rd1[0], 32'hCAFE_F00D);
        chk("ws_m1_hwdata", o_hwdata[0], 32'h1111_2222);
        clk_edge();
        settle();
        chk("ws_m0_data", 32'(o_dp[0]), 32'h1);
        clk_edge();

        // Reset while M0 in data phase and M1 waiting.
        trans_m[0] = 2'b10; addr_m[0] = 32'h5000_0000;
        cyc();
        trans_m[0] = 2'b00;
        cyc();
        trans_m[1] = 2'b10; addr_m[1] = 32'h6000_0000;
        cyc();
        trans_m[1] = 2'b00;
        HRESET = 1'b1;
        settle();
        chk("mr_pre_dp", 32'(o_dp[0]), 32'h1);
        chk("mr_pre_rdy1", 32'(o_rdy1[0]), 32'h0);
        clk_edge();
        HRESET = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            chk("mr_rdy0", 32'(o_rdy0[d]), 32'h1);
            chk("mr_rdy1", 32'(o_rdy1[d]), 32'h1);
            chk("mr_htrans", 32'(o_htrans[d]), 32'h0);
            chk("mr_dp", 32'(o_dp[d]), 32'h0);
            chk("mr_hwdata", o_hwdata[d], 32'h0);
        end
        clk_edge();
        settle();
        chk("mr_m1_lost", 32'(o_htrans[0]), 32'h0);
        clk_edge();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            HRESET = ($urandom_range(0, 99) == 0);
            HREADY = ($urandom_range(0, 3) != 0);
            HRDATA = $urandom();
            for (int m = 0; m < 2; m++) begin
                trans_m[m] = 2'($urandom_range(0, 3));
                addr_m[m]  = $urandom();
                write_m[m] = 1'($urandom_range(0, 1));
                size_m[m]  = 3'($urandom_range(0, 7));
                wdata_m[m] = $urandom();
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_lite_master_arb.md
Name: ahb_lite_master_arb

Overview:
Two-master AHB-lite arbiter placed in front of the system bus decoder. M0 is the CPU and M1 is a DMA engine. The block shares the single bus address/data path between them.
- Each master gets a 1-entry address-phase buffer.
- The bus address phase is driven from registers.
- Data-phase signals are steered to the owning master.
- Arbitration mode is selectable: fixed priority or round-robin.

Parameters:
RR, 0, arbitration mode: 0 = fixed priority (M0 wins), 1 = round-robin
AW, 32, address width

Ports:
HCLK  input  1  bus clock; all state on rising edge
HRESET  input  1  synchronous reset, active-high
HADDR_M0 / HADDR_M1  input  AW  master address
HTRANS_M0 / HTRANS_M1  input  2  master transfer type; bit1 = NONSEQ/SEQ request
HWRITE_M0 / HWRITE_M1  input  1  master write flag
HSIZE_M0 / HSIZE_M1  input  3  master transfer size
HWDATA_M0 / HWDATA_M1  input  32  master write data (data phase)
HREADY_M0 / HREADY_M1  output  1  per-master ready
HRDATA_M0 / HRDATA_M1  output  32  read data to master
HADDR  output  AW  bus address (registered)
HTRANS  output  2  bus transfer type (registered; 2'b10 or 2'b00 only)
HWRITE  output  1  bus write (registered)
HSIZE  output  3  bus size (registered)
HWDATA  output  32  bus write data (combinational mux)
HREADY  input  1  bus ready from decoder/slave mux
HRDATA  input  32  bus read data
DP_OWNER  output  2  one-hot data-phase owner {M1,M0}; 00 = none

Behaviour:
Per-master FSM x∈{0,1}, states IDLE/PEND/ADDR/DATA:
- IDLE:
  - HREADY_Mx = 1.
  - At an edge with HTRANS_Mx[1] = 1, capture HADDR/HWRITE/HSIZE_Mx into the buffer and go to PEND.
- PEND:
  - HREADY_Mx = 0.
  - At an edge with HREADY = 1 where x wins arbitration: load the bus registers from the buffer (HTRANS = 2'b10) and go to ADDR.
- ADDR:
  - HREADY_Mx = 0.
  - At an edge with HREADY = 1, go to DATA.
- DATA:
  - HREADY_Mx = HREADY.
  - HWDATA = HWDATA_Mx; DP_OWNER[x] = 1.
  - At an edge with HREADY = 1: go to PEND if HTRANS_Mx[1] = 1 at that edge (capture the new request), otherwise go to IDLE.

Shared rules:
- HRDATA_M0 = HRDATA_M1 = HRDATA (broadcast); a master samples it only when its own HREADY_Mx is high in DATA.
- HWDATA = 0 when DP_OWNER = 00.
- Bus register load happens only at an edge with HREADY = 1.
  - Candidates are masters in PEND at that edge.
  - If there is no candidate, HTRANS ← 2'b00 and HADDR/HWRITE/HSIZE hold their values.
- While HREADY = 0, all bus registers hold, DP_OWNER holds, and PEND masters stay PEND.
- SEQ requests are always issued as NONSEQ; HBURST/HPROT/HRESP are not supported.
- At most one master is in ADDR and at most one in DATA at any time.
  - Back-to-back pipelining is allowed: one master in DATA while the other is in ADDR.

Arbitration (evaluated only when both masters are in PEND at a load edge):
- RR = 0: M0 always wins.
- RR = 1: the master not equal to last_grant wins.
- last_grant updates on every load.

Latency: zero-wait slave, idle bus → request accepted at edge 0, on bus (ADDR) after edge 1, data completes at edge 3. HREADY_Mx is low for 2 cycles.

Reset (HRESET = 1 at an edge, also mid-transfer):
- All FSMs go to IDLE and buffers are discarded.
- HTRANS = 00, HADDR = 0, HWRITE = 0, HSIZE = 0, last_grant = M1.
- Outputs after reset: HREADY_M0/M1 = 1, DP_OWNER = 00, HWDATA = 0.
- A request presented during reset is not captured.

Test Plan:
1. Reset: hold HRESET 2 cycles with HTRANS_M0 = 2'b10, then release with HTRANS_M0 = 00 → HTRANS = 00, HREADY_M0/M1 = 1, DP_OWNER = 00; no bus transfer issued.
2. Single M0 read at 0x2000_0010, zero-wait slave with HRDATA = 0xDEADBEEF:
   - HADDR = 0x2000_0010, HTRANS = 10 one cycle after acceptance.
   - HREADY_M0 = 0, 0, then 1 with HRDATA_M0 = 0xDEADBEEF.
   - DP_OWNER = 01 in the completing cycle.
3. RR = 0, same-edge requests: M0 write 0x1 (HWDATA_M0 = 0xA5A5A5A5) and M1 read 0x2:
   - M0 is issued first; M1's address follows on the next cycle (back-to-back).
   - HWDATA = 0xA5A5A5A5 while DP_OWNER = 01; M1 completes one cycle after M0.
4. Both masters request continuously, 6 transfers each:
   - RR = 1 → issue order M0, M1, M0, M1…
   - RR = 0 → M1 is issued only in load cycles where M0 is not in PEND.
5. Slave inserts 3 wait states (HREADY = 0) during the M1 data phase while M0 is in ADDR:
   - HADDR/HTRANS hold M0's values; HREADY_M0 = HREADY_M1 = 0; DP_OWNER = 10 held.
   - M1 completes on the first HREADY = 1, and M0 enters DATA.
6. Assert HRESET while M0 is in DATA and M1 is in PEND → next cycle: both HREADY_Mx = 1, HTRANS = 00, DP_OWNER = 00; M1's request is lost.
